// File: rtl/isp_core.sv
// isp_core: auto-focus / auto-exposure engine over a byte-wide picture memory.
// Each request reads one picture (or a 6x6 focus window of it) and returns one
// 8-bit result. Exposure requests also write the ratio-adjusted bytes back in place.
module isp_core #(
    parameter int                MEM_LAT   = 2,
    parameter int                ADDR_W    = 18,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 18'h10000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        in_pic_no,
    input  logic              in_mode,
    input  logic [1:0]        in_ratio_mode,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int AE_BYTES = 3072;

    typedef enum logic [2:0] {
        S_IDLE, S_AF_RD, S_AE_RD, S_DRAIN, S_CALC, S_OUT
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        pic_q;
    logic              mode_q;
    logic [1:0]        ratio_q;
    logic [11:0]       ae_cnt;
    logic [1:0]        af_ch;
    logic [2:0]        af_row, af_col;
    logic [7:0]        drain_cnt;
    logic              start;
    logic              af_last;
    logic [4:0]        af_row_abs, af_col_abs;
    logic [11:0]       rd_off;
    logic [ADDR_W-1:0] pic_base;

    logic              vld_p  [MEM_LAT];
    logic [ADDR_W-1:0] addr_p [MEM_LAT];
    logic [1:0]        ch_p   [MEM_LAT];
    logic [2:0]        row_p  [MEM_LAT];
    logic [2:0]        col_p  [MEM_LAT];

    logic              ret_vld;
    logic [1:0]        ret_ch;
    logic [2:0]        ret_row, ret_col;
    logic [7:0]        adj_byte, acc_byte, term;

    logic [17:0]       ae_sum;
    logic [7:0]        gray [0:5][0:5];
    logic [15:0]       d0_sum, d1_sum, d2_sum;
    logic [15:0]       d0, d1, d2;
    logic [1:0]        af_pick;
    logic [7:0]        res_q;

    // Exposure scaling; x2 saturates at 255.
    function automatic logic [7:0] expose_adj(input logic [7:0] p, input logic [1:0] ratio);
        logic [7:0] r;
        case (ratio)
            2'd0:    r = {2'b00, p[7:2]};
            2'd1:    r = {1'b0, p[7:1]};
            2'd2:    r = p;
            default: r = p[7] ? 8'hFF : {p[6:0], 1'b0};
        endcase
        return r;
    endfunction

    // Per-channel gray contribution: R>>2, G>>1, B>>2.
    function automatic logic [7:0] gray_term(input logic [7:0] p, input logic [1:0] ch);
        return (ch == 2'd1) ? {1'b0, p[7:1]} : {2'b00, p[7:2]};
    endfunction

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d < 0) d = -d;
        return d[7:0];
    endfunction

    assign start   = (state == S_IDLE) && in_valid;
    assign af_last = (af_ch == 2'd2) && (af_row == 3'd5) && (af_col == 3'd5);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and strobe outputs.
    always_comb begin
        state_nxt = state;
        mem_ren   = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'd0;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = in_mode ? S_AE_RD : S_AF_RD;
            S_AF_RD: begin
                mem_ren = 1'b1;
                if (af_last) state_nxt = S_DRAIN;
            end
            S_AE_RD: begin
                mem_ren = 1'b1;
                if (ae_cnt == 12'(AE_BYTES - 1)) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (drain_cnt == 8'(MEM_LAT - 1)) state_nxt = mode_q ? S_OUT : S_CALC;
            S_CALC:  state_nxt = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = mode_q ? ae_sum[17:10] : res_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch and read/drain counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pic_q     <= 4'd0;
            mode_q    <= 1'b0;
            ratio_q   <= 2'd0;
            ae_cnt    <= 12'd0;
            af_ch     <= 2'd0;
            af_row    <= 3'd0;
            af_col    <= 3'd0;
            drain_cnt <= 8'd0;
        end else if (start) begin
            pic_q     <= in_pic_no;
            mode_q    <= in_mode;
            ratio_q   <= in_ratio_mode;
            ae_cnt    <= 12'd0;
            af_ch     <= 2'd0;
            af_row    <= 3'd0;
            af_col    <= 3'd0;
            drain_cnt <= 8'd0;
        end else begin
            case (state)
                S_AE_RD: ae_cnt <= ae_cnt + 12'd1;
                S_AF_RD: begin
                    if (af_col == 3'd5) begin
                        af_col <= 3'd0;
                        if (af_row == 3'd5) begin
                            af_row <= 3'd0;
                            af_ch  <= af_ch + 2'd1;
                        end else begin
                            af_row <= af_row + 3'd1;
                        end
                    end else begin
                        af_col <= af_col + 3'd1;
                    end
                end
                S_DRAIN: drain_cnt <= drain_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    // Focus window is rows/cols 13..18 of each 32x32 channel plane.
    assign af_row_abs = 5'd13 + {2'b00, af_row};
    assign af_col_abs = 5'd13 + {2'b00, af_col};
    assign rd_off     = mode_q ? ae_cnt : {af_ch, af_row_abs, af_col_abs};
    assign pic_base   = BASE_ADDR + ADDR_W'({pic_q, 11'd0}) + ADDR_W'({pic_q, 10'd0});
    assign mem_addr   = pic_base + ADDR_W'(rd_off);

    // Read-tag valid chain, aligned with the memory latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= mem_ren;
            for (int i = 1; i < MEM_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Read-tag payload chain: address for write-back, channel and window position.
    always_ff @(posedge clk) begin
        addr_p[0] <= mem_addr;
        ch_p[0]   <= mode_q ? ae_cnt[11:10] : af_ch;
        row_p[0]  <= af_row;
        col_p[0]  <= af_col;
        for (int i = 1; i < MEM_LAT; i++) begin
            addr_p[i] <= addr_p[i-1];
            ch_p[i]   <= ch_p[i-1];
            row_p[i]  <= row_p[i-1];
            col_p[i]  <= col_p[i-1];
        end
    end

    // ---- return stage: tag meets mem_rdata ----
    assign ret_vld   = vld_p[MEM_LAT-1];
    assign ret_ch    = ch_p[MEM_LAT-1];
    assign ret_row   = row_p[MEM_LAT-1];
    assign ret_col   = col_p[MEM_LAT-1];
    assign adj_byte  = expose_adj(mem_rdata, ratio_q);
    assign acc_byte  = mode_q ? adj_byte : mem_rdata;
    assign term      = gray_term(acc_byte, ret_ch);
    assign mem_wen   = ret_vld && mode_q && (ratio_q != 2'd2);
    assign mem_waddr = addr_p[MEM_LAT-1];
    assign mem_wdata = adj_byte;

    // Exposure sum and focus gray array, cleared for every new request.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            ae_sum <= 18'd0;
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++)
                    gray[r][c] <= 8'd0;
        end else if (ret_vld) begin
            if (mode_q) begin
                ae_sum <= ae_sum + 18'(term);
            end else begin
                for (int r = 0; r < 6; r++)
                    for (int c = 0; c < 6; c++)
                        if (ret_row == 3'(r) && ret_col == 3'(c))
                            gray[r][c] <= gray[r][c] + term;
            end
        end
    end

    // ---- calc stage: neighbour contrast of the three nested windows ----
    always_comb begin
        d0_sum = 16'd0;
        d1_sum = 16'd0;
        d2_sum = 16'd0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 5; c++) begin
                d2_sum = d2_sum + 16'(abs_diff(gray[r][c], gray[r][c+1]));
                if (r >= 1 && r <= 4 && c >= 1 && c <= 3)
                    d1_sum = d1_sum + 16'(abs_diff(gray[r][c], gray[r][c+1]));
                if (r >= 2 && r <= 3 && c == 2)
                    d0_sum = d0_sum + 16'(abs_diff(gray[r][c], gray[r][c+1]));
            end
        end
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 6; c++) begin
                d2_sum = d2_sum + 16'(abs_diff(gray[r][c], gray[r+1][c]));
                if (r >= 1 && r <= 3 && c >= 1 && c <= 4)
                    d1_sum = d1_sum + 16'(abs_diff(gray[r][c], gray[r+1][c]));
                if (r == 2 && c >= 2 && c <= 3)
                    d0_sum = d0_sum + 16'(abs_diff(gray[r][c], gray[r+1][c]));
            end
        end
        d0 = d0_sum >> 2;
        d1 = d1_sum >> 4;
        d2 = d2_sum / 16'd36;
        if (d0 >= d1 && d0 >= d2)     af_pick = 2'd0;
        else if (d1 > d0 && d1 >= d2) af_pick = 2'd1;
        else                          af_pick = 2'd2;
    end

    // Capture the focus decision for the output cycle.
    always_ff @(posedge clk) begin
        if (rst)                  res_q <= 8'd0;
        else if (state == S_CALC) res_q <= {6'd0, af_pick};
    end

endmodule

// File: tb/tb_isp_core.sv
// tb_isp_core: scoreboard bench for isp_core with a latency-MEM_LAT byte memory model.
module tb_isp_core;

    localparam int                MEM_LAT = 2;
    localparam int                ADDR_W  = 18;
    localparam logic [ADDR_W-1:0] BASE    = 18'h10000;
    localparam int                LAT_MAX = 3100 + MEM_LAT;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [3:0]        in_pic_no;
    logic              in_mode;
    logic [1:0]        in_ratio_mode;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    isp_core #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pic_no(in_pic_no),
        .in_mode(in_mode), .in_ratio_mode(in_ratio_mode), .out_valid(out_valid),
        .out_data(out_data), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [0:(1<<ADDR_W)-1];
    logic [7:0]  rd_pipe [MEM_LAT];
    logic        fill_go = 1'b0;
    logic [3:0]  fill_pic = 4'd0;
    logic [1:0]  fill_kind = 2'd0;
    logic [7:0]  fill_val = 8'd0;
    int          fill_seed = 0;
    int          wen_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q [$];

    function automatic logic [ADDR_W-1:0] addr_of(input int pic, input int off);
        return ADDR_W'(int'(BASE) + pic * 3072 + off);
    endfunction

    // kind 0 uniform, 1 checkerboard 0/255, 2 pseudo-random, 3 one bright pixel at (14,14)
    function automatic logic [7:0] pat(input logic [1:0] kind, input logic [7:0] val,
                                       input int seed, input int i);
        int row, col;
        logic [31:0] hv;
        row = (i % 1024) / 32;
        col = i % 32;
        hv  = 32'(i) * 32'd1103515245 + 32'(seed) * 32'd12345 + 32'd7;
        case (kind)
            2'd0:    return val;
            2'd1:    return ((row + col) % 2 == 1) ? 8'hFF : 8'h00;
            2'd2:    return hv[23:16];
            default: return (row == 14 && col == 14) ? 8'hFF : 8'h00;
        endcase
    endfunction

    // Memory model: fills, DUT writes and the read latency line.
    always @(posedge clk) begin
        if (fill_go)
            for (int i = 0; i < 3072; i++)
                mem[addr_of(int'(fill_pic), i)] <= pat(fill_kind, fill_val, fill_seed, i);
        if (mem_wen) begin
            mem[mem_waddr] <= mem_wdata;
            wen_cnt <= wen_cnt + 1;
        end
        rd_pipe[0] <= mem_ren ? mem[mem_addr] : 8'h00;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    function automatic logic [7:0] adj_m(input logic [7:0] p, input logic [1:0] ratio);
        int v;
        case (ratio)
            2'd0:    v = p / 4;
            2'd1:    v = p / 2;
            2'd2:    v = p;
            default: v = (p * 2 > 255) ? 255 : p * 2;
        endcase
        return 8'(v);
    endfunction

    function automatic logic [7:0] ae_model(input int pic, input logic [1:0] ratio);
        int sum;
        int a;
        sum = 0;
        for (int i = 0; i < 3072; i++) begin
            a = int'(adj_m(mem[addr_of(pic, i)], ratio));
            sum += (i / 1024 == 1) ? a / 2 : a / 4;
        end
        return 8'(sum / 1024);
    endfunction

    function automatic bit in_win(input int r0, input int c0, input int r1, input int c1,
                                  input int lo, input int hi);
        return r0 >= lo && r0 <= hi && c0 >= lo && c0 <= hi &&
               r1 >= lo && r1 <= hi && c1 >= lo && c1 <= hi;
    endfunction

    function automatic logic [7:0] af_model(input int pic);
        int g [6][6];
        int s0, s1, s2, d, a0, a1, a2;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                g[r][c] = mem[addr_of(pic, (13 + r) * 32 + 13 + c)] / 4
                        + mem[addr_of(pic, 1024 + (13 + r) * 32 + 13 + c)] / 2
                        + mem[addr_of(pic, 2048 + (13 + r) * 32 + 13 + c)] / 4;
        s0 = 0; s1 = 0; s2 = 0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
                if (c < 5) begin
                    d = g[r][c] - g[r][c+1];
                    if (d < 0) d = -d;
                    s2 += d;
                    if (in_win(r, c, r, c + 1, 1, 4)) s1 += d;
                    if (in_win(r, c, r, c + 1, 2, 3)) s0 += d;
                end
                if (r < 5) begin
                    d = g[r][c] - g[r+1][c];
                    if (d < 0) d = -d;
                    s2 += d;
                    if (in_win(r, c, r + 1, c, 1, 4)) s1 += d;
                    if (in_win(r, c, r + 1, c, 2, 3)) s0 += d;
                end
            end
        a0 = s0 / 4; a1 = s1 / 16; a2 = s2 / 36;
        if (a0 >= a1 && a0 >= a2) return 8'd0;
        if (a1 > a0 && a1 >= a2)  return 8'd1;
        return 8'd2;
    endfunction

    task automatic fill(input int pic, input logic [1:0] kind, input logic [7:0] val, input int seed);
        @(negedge clk);
        fill_pic = 4'(pic); fill_kind = kind; fill_val = val; fill_seed = seed; fill_go = 1'b1;
        @(negedge clk);
        fill_go = 1'b0;
    endtask

    task automatic issue(input int pic, input logic mode, input logic [1:0] ratio);
        @(negedge clk);
        in_valid = 1'b1; in_pic_no = 4'(pic); in_mode = mode; in_ratio_mode = ratio;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; d is X and lat is -1 when the bound expires.
    task automatic wait_out(output logic [7:0] d, output int lat);
        bit found;
        found = 1'b0; d = 'x; lat = 1;
        while (!found && lat <= LAT_MAX + 20) begin
            if (out_valid === 1'b1) begin
                found = 1'b1;
                d = out_data;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!found) lat = -1;
    endtask

    task automatic run_req(input int pic, input logic mode, input logic [1:0] ratio,
                           output logic [7:0] d, output int lat);
        issue(pic, mode, ratio);
        wait_out(d, lat);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_pic_no = 4'd0; in_mode = 1'b0; in_ratio_mode = 2'd0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL reset_mem_ren: got %b expected 0", mem_ren); end
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_mem_wen: got %b expected 0", mem_wen); end
        rst = 1'b0;
    endtask

    task automatic test_af_uniform;
        logic [7:0] d, e;
        int lat;
        fill(0, 2'd0, 8'd100, 0);
        exp_q.push_back(8'd0);
        run_req(0, 1'b0, 2'd0, d, lat);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL af_uniform: got %0d expected %0d", d, e); end
        checks++; if (lat < 1 || lat > LAT_MAX) begin errors++; $display("FAIL af_latency: got %0d expected 1..%0d", lat, LAT_MAX); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_data !== 8'd0) begin
            errors++; $display("FAIL out_after_pulse: got valid=%b data=%0d expected 0/0", out_valid, out_data); end
    endtask

    task automatic test_af_checker;
        logic [7:0] d, e;
        int lat;
        fill(1, 2'd1, 8'd0, 0);
        exp_q.push_back(8'd2);
        run_req(1, 1'b0, 2'd0, d, lat);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL af_checker: got %0d expected %0d", d, e); end
    endtask

    task automatic test_af_window1;
        logic [7:0] d, e;
        int lat;
        fill(7, 2'd3, 8'd0, 0);
        exp_q.push_back(8'd1);
        run_req(7, 1'b0, 2'd0, d, lat);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL af_window1: got %0d expected %0d", d, e); end
    endtask

    task automatic test_af_random;
        logic [7:0] d, e;
        int lat;
        for (int s = 1; s <= 3; s++) begin
            fill(8, 2'd2, 8'd0, s * 77);
            exp_q.push_back(af_model(8));
            run_req(8, 1'b0, 2'd0, d, lat);
            e = exp_q.pop_front();
            checks++; if (d !== e) begin errors++; $display("FAIL af_random_%0d: got %0d expected %0d", s, d, e); end
        end
    endtask

    task automatic test_ae_ratio2;
        logic [7:0] d, e;
        int lat, w0;
        fill(2, 2'd0, 8'd100, 0);
        w0 = wen_cnt;
        exp_q.push_back(8'd100);
        run_req(2, 1'b1, 2'd2, d, lat);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL ae_ratio2: got %0d expected %0d", d, e); end
        checks++; if (lat < 1 || lat > LAT_MAX) begin errors++; $display("FAIL ae_latency: got %0d expected 1..%0d", lat, LAT_MAX); end
        @(negedge clk);
        checks++; if (wen_cnt - w0 != 0) begin errors++; $display("FAIL ae_ratio2_writes: got %0d expected 0", wen_cnt - w0); end
    endtask

    task automatic test_ae_saturate;
        logic [7:0] d, e;
        int lat, w0;
        fill(3, 2'd0, 8'd200, 0);
        w0 = wen_cnt;
        exp_q.push_back(8'd253);
        run_req(3, 1'b1, 2'd3, d, lat);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL ae_ratio3: got %0d expected %0d", d, e); end
        @(negedge clk);
        checks++; if (wen_cnt - w0 != 3072) begin errors++; $display("FAIL ae_ratio3_writes: got %0d expected 3072", wen_cnt - w0); end
        checks++; if (mem[addr_of(3, 0)] !== 8'd255) begin errors++; $display("FAIL ae_sat_mem_first: got %0d expected 255", mem[addr_of(3, 0)]); end
        checks++; if (mem[addr_of(3, 3071)] !== 8'd255) begin errors++; $display("FAIL ae_sat_mem_last: got %0d expected 255", mem[addr_of(3, 3071)]); end
        exp_q.push_back(8'd253);
        run_req(3, 1'b1, 2'd2, d, lat);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL ae_persist: got %0d expected %0d", d, e); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d, e;
        int lat;
        fill(4, 2'd0, 8'd100, 0);
        exp_q.push_back(8'd24);
        exp_q.push_back(8'd5);
        run_req(4, 1'b1, 2'd0, d, lat);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL ae_ratio0_first: got %0d expected %0d", d, e); end
        run_req(4, 1'b1, 2'd0, d, lat);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL ae_ratio0_second: got %0d expected %0d", d, e); end
    endtask

    task automatic test_reset_abort;
        logic [7:0] d, e;
        int lat, w0;
        fill(5, 2'd0, 8'd100, 0);
        issue(5, 1'b1, 2'd0);
        repeat (500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        w0 = wen_cnt;
        checks++; if (mem_ren !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got ren=%b valid=%b expected 0/0", mem_ren, out_valid); end
        repeat (5) @(negedge clk);
        checks++; if (wen_cnt - w0 != 0) begin errors++; $display("FAIL abort_writes: got %0d expected 0", wen_cnt - w0); end
        checks++; if (mem[addr_of(5, 0)] !== 8'd25) begin errors++; $display("FAIL abort_mem_head: got %0d expected 25", mem[addr_of(5, 0)]); end
        checks++; if (mem[addr_of(5, 3071)] !== 8'd100) begin errors++; $display("FAIL abort_mem_tail: got %0d expected 100", mem[addr_of(5, 3071)]); end
        exp_q.push_back(ae_model(5, 2'd2));
        run_req(5, 1'b1, 2'd2, d, lat);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL abort_next_req: got %0d expected %0d", d, e); end
    endtask

    task automatic test_ae_random;
        logic [7:0] d, e, orig;
        int lat;
        fill(6, 2'd2, 8'd0, 4242);
        @(negedge clk);
        orig = mem[addr_of(6, 1234)];
        exp_q.push_back(ae_model(6, 2'd1));
        run_req(6, 1'b1, 2'd1, d, lat);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL ae_random: got %0d expected %0d", d, e); end
        @(negedge clk);
        checks++; if (mem[addr_of(6, 1234)] !== orig / 2) begin
            errors++; $display("FAIL ae_random_mem: got %0d expected %0d", mem[addr_of(6, 1234)], orig / 2); end
    endtask

    task automatic test_busy_ignore;
        logic [7:0] d, e;
        int lat, w0;
        fill(9, 2'd0, 8'd100, 0);
        w0 = wen_cnt;
        exp_q.push_back(8'd0);
        issue(9, 1'b0, 2'd0);
        repeat (20) @(negedge clk);
        issue(9, 1'b1, 2'd0);
        wait_out(d, lat);
        e = exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL busy_result: got %0d expected %0d", d, e); end
        repeat (3) @(negedge clk);
        checks++; if (mem_ren !== 1'b0 || wen_cnt - w0 != 0) begin
            errors++; $display("FAIL busy_ignored: got ren=%b writes=%0d expected 0/0", mem_ren, wen_cnt - w0); end
    endtask

    initial begin
        test_reset();
        test_af_uniform();
        test_af_checker();
        test_af_window1();
        test_af_random();
        test_ae_ratio2();
        test_ae_saturate();
        test_back_to_back();
        test_reset_abort();
        test_ae_random();
        test_busy_ignore();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
